// File: rtl/moving_average3_inverse.sv
// moving_average3_inverse: recovers signed samples x[n] from a WINDOW-tap moving-sum stream
//   system1000 / system1000_rst : clock, async active-high reset
//   clr_i                       : sync clear of history, output register and error flag
//   sum_i / sum_valid_i / sum_ready_o : moving-sum input handshake
//   x_o / x_valid_o / x_ready_i : recovered-sample output handshake
//   err_o                       : sticky saturation flag
module moving_average3_inverse #(
    parameter int WINDOW = 3,
    parameter int DW     = 8,
    parameter int SW     = 10
) (
    input  logic                 system1000,
    input  logic                 system1000_rst,
    input  logic                 clr_i,
    input  logic signed [SW-1:0] sum_i,
    input  logic                 sum_valid_i,
    output logic                 sum_ready_o,
    output logic signed [DW-1:0] x_o,
    output logic                 x_valid_o,
    input  logic                 x_ready_i,
    output logic                 err_o
);
    localparam logic signed [SW:0] MAX_V = {{(SW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW:0] MIN_V = {{(SW-DW+2){1'b1}}, {(DW-1){1'b0}}};
    logic signed [DW-1:0] hist_q [1:WINDOW-1];
    logic signed [DW-1:0] hist_d [1:WINDOW-1];
    logic signed [SW:0]   run_q, run_d;
    logic signed [DW-1:0] x_q, x_d;
    logic                 xv_q, xv_d;
    logic                 err_q, err_d;
    logic signed [SW:0]   diff;
    logic signed [DW-1:0] x_sat;
    logic                 take, hi, lo;
    always_comb begin
        sum_ready_o = !clr_i && (!xv_q || x_ready_i);
        take = sum_valid_i && sum_ready_o;
        diff = {sum_i[SW-1], sum_i} - run_q;
        hi = diff > MAX_V;
        lo = diff < MIN_V;
        x_sat = hi ? MAX_V[DW-1:0] : lo ? MIN_V[DW-1:0] : diff[DW-1:0];
        hist_d = hist_q;
        run_d = run_q;
        x_d = x_q;
        xv_d = xv_q && !x_ready_i;
        err_d = err_q;
        if (clr_i) begin
            for (int k = 1; k < WINDOW; k++) hist_d[k] = '0;
            run_d = '0;
            x_d = '0;
            xv_d = 1'b0;
            err_d = 1'b0;
        end else if (take) begin
            x_d = x_sat;
            xv_d = 1'b1;
            err_d = err_q || hi || lo;
            // history and running sum track the saturated (emitted) value
            run_d = run_q + {{(SW+1-DW){x_sat[DW-1]}}, x_sat}
                          - {{(SW+1-DW){hist_q[WINDOW-1][DW-1]}}, hist_q[WINDOW-1]};
            hist_d[1] = x_sat;
            for (int k = 2; k < WINDOW; k++) hist_d[k] = hist_q[k-1];
        end
    end
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            for (int k = 1; k < WINDOW; k++) hist_q[k] <= '0;
            run_q <= '0;
            x_q <= '0;
            xv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            run_q <= run_d;
            x_q <= x_d;
            xv_q <= xv_d;
            err_q <= err_d;
        end
    end
    assign x_o = x_q;
    assign x_valid_o = xv_q;
    assign err_o = err_q;
endmodule

// File: doc/moving_average3_inverse.md
# moving_average3_inverse

Inverse filter for the three-tap moving-sum datapath. It accepts the running sum s[n] = x[n] + x[n-1] + x[n-2] as a signed stream and reconstructs the original signed 8-bit samples x[n] by subtracting the previously recovered samples. It sits at the far end of the filtered link: it consumes the moving-sum stream and hands recovered samples downstream over a valid/ready handshake. It is also the loop-back checker for the moving-average block.

## Interface

Parameters:
- `WINDOW`, default 3: window length N; legal range 2..8.
- `DW`, default 8: sample width (signed).
- `SW`, default 10: input sum width (signed); must be ≥ DW + ceil(log2(WINDOW)).

Ports:
- `system1000`, in, 1: clock; all state changes on rising edge.
- `system1000_rst`, in, 1: asynchronous reset, active-high.
- `clr_i`, in, 1: synchronous clear of history, output register and error flag.
- `sum_i`, in, SW: signed moving sum s[n].
- `sum_valid_i`, in, 1: `sum_i` valid.
- `sum_ready_o`, out, 1: block can accept `sum_i` this cycle.
- `x_o`, out, DW: signed recovered sample.
- `x_valid_o`, out, 1: `x_o` valid.
- `x_ready_i`, in, 1: downstream accepts `x_o`.
- `err_o`, out, 1: sticky saturation flag.

## Operation

- State:
  - History shift register H[1..N-1] of the last N-1 emitted samples, DW each.
  - Running sum R = ΣH, width SW+1.
  - Output register holding `x_o` and `x_valid_o`.
  - Sticky `err_o`.
- Accept: a transfer occurs when `sum_valid_i && sum_ready_o`.
- Ready rule: `sum_ready_o = !clr_i && (!x_valid_o || x_ready_i)`.
  - This is combinational from `x_valid_o`, `x_ready_i` and `clr_i`.
  - It is never dependent on `sum_valid_i`.
- On transfer:
  - d = sext(sum_i) − R, computed at SW+1 bits, no overflow possible.
  - x = sat(d):
    - d > 2^(DW-1)−1 gives 2^(DW-1)−1.
    - d < −2^(DW-1) gives −2^(DW-1).
    - Any clip sets `err_o`.
  - `x_o` ← x and `x_valid_o` ← 1.
  - H shifts: H[1] ← x, H[k] ← H[k-1], and the oldest entry H[N-1] is dropped.
  - R ← R + x − H[N-1]. The history stores the saturated value, i.e. exactly what was emitted.
- Output drain:
  - If `x_valid_o && x_ready_i` with no new transfer, `x_valid_o` ← 0.
  - `x_o` holds its last value.
- Stall: while `x_valid_o && !x_ready_i`, `x_o` and `x_valid_o` are held stable and no input is accepted.
- Start-up: after reset or clear, the history is all zero, i.e. x[-1] = x[-2] = 0. This matches the zero initial state of the moving-sum source.
- `clr_i` (synchronous), in the cycle it is asserted:
  - H, R, `err_o` and `x_valid_o` go to 0; `x_o` goes to 0.
  - `sum_ready_o` is 0, so no input is lost silently.
  - Clear takes priority over a pending drain.
- `err_o` is cleared only by reset or `clr_i`.
- No FSM beyond the output-register full/empty state:
  - EMPTY → FULL on transfer.
  - FULL → EMPTY on drain with no transfer.
  - FULL → FULL on drain plus transfer, or on stall.

## Timing

- Reset values: `x_o` = 0, `x_valid_o` = 0, `err_o` = 0, H = 0, R = 0. `sum_ready_o` = 1 after reset release when `clr_i` = 0.
- Reset mid-operation: everything returns to the reset values immediately (asynchronous). A sample in the output register is discarded.
- Latency: the sample accepted at edge k is presented on `x_o` with `x_valid_o` = 1 after edge k.
- Throughput: one sample per cycle when `x_ready_i` is held high.
- Simultaneous drain and accept in one cycle: the new sample replaces the old with no bubble, and `x_valid_o` stays 1.
- `err_o` rises in the same cycle `x_o` presents the clipped value.

## Test plan

- From reset, feed sums 10, 30, 60, 90, 120 back-to-back (x = 10, 20, 30, 40, 50) with `x_ready_i` = 1.
  - Required: `x_o` = 10, 20, 30, 40, 50 on consecutive cycles, one cycle after each accept.
  - Required: `err_o` = 0.
- Same stream with `x_ready_i` low for 3 cycles after the second output.
  - Required: `sum_ready_o` = 0 and `x_o` held at 20 during the stall.
  - Required: the remaining outputs are 30, 40, 50 with no loss or duplication.
- Negative extreme: sums −128, −256, −384, −384.
  - Required: outputs −128, −128, −128, −128, with no `err_o`.
- Saturation: from reset, sum 200.
  - Required: `x_o` = 127 and `err_o` = 1 from that cycle.
  - Follow-up: a next sum of 127 gives 127 − 127 = 0, and `err_o` stays 1.
- Clear mid-stream: after outputs 10, 20, assert `clr_i` for one cycle while `sum_valid_i` = 1.
  - Required: `sum_ready_o` = 0 in that cycle; `x_valid_o`, `err_o` and the history go to 0.
  - Required: the next sum 5 yields `x_o` = 5.
- Asynchronous reset asserted between edges with `x_valid_o` = 1.
  - Required: `x_valid_o` and `x_o` go to 0 immediately.
  - Required: the restarted stream 10, 30, 60 yields 10, 20, 30.
